// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three requester FIFOs (ALU, MEM, BRU) feed one
// registered broadcast port under round-robin arbitration.
module cdb_arbiter #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [2:0]                req_valid,
    input  logic [2:0][TAGW-1:0]      req_tag,
    input  logic [2:0][31:0]          req_value,
    output logic [2:0]                req_ready,
    output logic [TAGW-1:0]           cdb_num,
    output logic [31:0]               cdb_value,
    output logic [1:0]                cdb_src,
    output logic [2:0]                pending
);

    localparam int NREQ = 3;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);

    logic [CW-1:0]   count  [NREQ];
    logic [PW-1:0]   wr_ptr [NREQ];
    logic [PW-1:0]   rd_ptr [NREQ];
    logic [TAGW-1:0] tag_mem [NREQ][DEPTH];
    logic [31:0]     val_mem [NREQ][DEPTH];

    logic [1:0]      rr_ptr;
    logic [2:0]      nonempty;
    logic [2:0]      push;
    logic [2:0]      pop;
    logic            grant_vld;
    logic [1:0]      grant_idx;
    logic [1:0]      scan_idx;
    logic [TAGW-1:0] head_tag;
    logic [31:0]     head_value;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [1:0] rr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Ready and pending come only from registered counts; a pop in the
    // same cycle does not open a slot for a push.
    always_comb begin
        nonempty  = '0;
        req_ready = '0;
        push      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            nonempty[k]  = (count[k] != '0);
            req_ready[k] = (count[k] < CW'(DEPTH));
            push[k]      = req_valid[k] && req_ready[k] && !flush &&
                           (req_tag[k] != '0);
        end
    end

    assign pending = nonempty;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = rr_ptr;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_vld && nonempty[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
            scan_idx = rr_inc(scan_idx);
        end
    end

    always_comb begin
        pop = '0;
        if (grant_vld && !flush) begin
            pop[grant_idx] = 1'b1;
        end
        head_tag   = tag_mem[grant_idx][rd_ptr[grant_idx]];
        head_value = val_mem[grant_idx][rd_ptr[grant_idx]];
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (push[k]) begin
                tag_mem[k][wr_ptr[k]] <= req_tag[k];
                val_mem[k][wr_ptr[k]] <= req_value[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                count[k]  <= '0;
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
            rr_ptr    <= '0;
            cdb_num   <= '0;
            cdb_value <= '0;
            cdb_src   <= 2'd3;
        end else if (flush) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                count[k]  <= '0;
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
            rr_ptr    <= '0;
            cdb_num   <= '0;
            cdb_value <= '0;
            cdb_src   <= 2'd3;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= ptr_inc(wr_ptr[k]);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= ptr_inc(rd_ptr[k]);
                end
                case ({push[k], pop[k]})
                    2'b10:   count[k] <= count[k] + CW'(1);
                    2'b01:   count[k] <= count[k] - CW'(1);
                    default: count[k] <= count[k];
                endcase
            end
            if (grant_vld) begin
                cdb_num   <= head_tag;
                cdb_value <= head_value;
                cdb_src   <= grant_idx;
                rr_ptr    <= rr_inc(grant_idx);
            end else begin
                cdb_num   <= '0;
                cdb_value <= '0;
                cdb_src   <= 2'd3;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued as stimulus
// is driven and matched against every non-idle cdb cycle.
module tb_cdb_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [2:0]       req_valid;
    logic [2:0][2:0]  req_tag;
    logic [2:0][31:0] req_value;
    logic [2:0]       req_ready;
    logic [2:0]       cdb_num;
    logic [31:0]      cdb_value;
    logic [1:0]       cdb_src;
    logic [2:0]       pending;

    typedef struct {
        logic [2:0]  tag;
        logic [31:0] value;
        logic [1:0]  src;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    cdb_arbiter #(.DEPTH(2), .TAGW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_value (req_value),
        .req_ready (req_ready),
        .cdb_num   (cdb_num),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic expect_bcast(input logic [2:0] tag, input logic [31:0] value, input logic [1:0] src);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        e.src   = src;
        sb.push_back(e);
    endtask

    task automatic drive(input int k, input logic [2:0] tag, input logic [31:0] value);
        req_valid[k] = 1'b1;
        req_tag[k]   = tag;
        req_value[k] = value;
    endtask

    task automatic idle_req(input int k);
        req_valid[k] = 1'b0;
        req_tag[k]   = '0;
        req_value[k] = '0;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_tag   = '0;
        req_value = '0;
    endtask

    // Advance one edge, then match any broadcast against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (cdb_num !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_bcast", cdb_num, 0);
            end else begin
                e = sb.pop_front();
                chk("cdb_num", cdb_num, e.tag);
                chk("cdb_value", cdb_value, e.value);
                chk("cdb_src", cdb_src, e.src);
            end
        end else begin
            chk("idle_value", cdb_value, 0);
            chk("idle_src", cdb_src, 3);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_num"}, cdb_num, 0);
        chk({name, "_value"}, cdb_value, 0);
        chk({name, "_src"}, cdb_src, 3);
        chk({name, "_pending"}, pending, 0);
        chk({name, "_ready"}, req_ready, 3'b111);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        idle_all();
        #12;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single ALU result
        drive(0, 3'd3, 32'h1234);
        expect_bcast(3'd3, 32'h1234, 2'd0);
        tick();
        idle_all();
        chk("s1_no_early_bcast", cdb_num, 0);
        chk("s1_pending", pending, 3'b001);
        tick();
        chk("s1_num_edge2", cdb_num, 3);
        chk("s1_src_edge2", cdb_src, 0);
        tick();
        chk("s1_num_edge3", cdb_num, 0);
        chk("s1_pending_empty", pending, 0);

        // Three-way contention from rr_ptr=0
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 3'd1, 32'hA0);
        drive(1, 3'd2, 32'hA1);
        drive(2, 3'd4, 32'hA2);
        expect_bcast(3'd1, 32'hA0, 2'd0);
        expect_bcast(3'd2, 32'hA1, 2'd1);
        expect_bcast(3'd4, 32'hA2, 2'd2);
        tick();
        idle_all();
        tick();
        chk("s2_first", cdb_num, 1);
        tick();
        chk("s2_second", cdb_num, 2);
        tick();
        chk("s2_third", cdb_num, 4);
        // rr_ptr back at 0: ALU wins over MEM
        drive(1, 3'd5, 32'hB1);
        drive(0, 3'd6, 32'hB0);
        expect_bcast(3'd6, 32'hB0, 2'd0);
        expect_bcast(3'd5, 32'hB1, 2'd1);
        tick();
        idle_all();
        tick();
        tick();
        tick();

        // MEM FIFO fills while ALU and BRU stay busy
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_bcast(3'd1, 32'hC1, 2'd0);
        expect_bcast(3'd5, 32'hD5, 2'd1);
        expect_bcast(3'd4, 32'hE4, 2'd2);
        expect_bcast(3'd2, 32'hC2, 2'd0);
        expect_bcast(3'd6, 32'hD6, 2'd1);
        expect_bcast(3'd3, 32'hE3, 2'd2);
        expect_bcast(3'd3, 32'hC3, 2'd0);
        expect_bcast(3'd7, 32'hD7, 2'd1);
        drive(0, 3'd1, 32'hC1);
        drive(1, 3'd5, 32'hD5);
        drive(2, 3'd4, 32'hE4);
        tick();
        drive(0, 3'd2, 32'hC2);
        drive(1, 3'd6, 32'hD6);
        drive(2, 3'd3, 32'hE3);
        tick();
        chk("s3_ready_after_2nd", req_ready, 3'b001);
        drive(0, 3'd3, 32'hC3);
        drive(1, 3'd7, 32'hD7);
        idle_req(2);
        tick();
        chk("s3_ready_after_mem_pop", req_ready, 3'b010);
        idle_req(0);
        tick();
        idle_all();
        chk("s3_ready_after_tag7", req_ready, 3'b100);
        chk("s3_pending_full", pending, 3'b111);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        chk("s3_drained", pending, 0);

        // Flush with entries buffered and a same-edge request
        drive(0, 3'd1, 32'hF0);
        drive(1, 3'd2, 32'hF1);
        drive(2, 3'd3, 32'hF2);
        tick();
        drive(0, 3'd4, 32'hF3);
        drive(1, 3'd5, 32'hF4);
        drive(2, 3'd6, 32'hF5);
        expect_bcast(3'd3, 32'hF2, 2'd2);
        tick();
        chk("s4_pending_before", pending, 3'b111);
        idle_all();
        flush = 1'b1;
        drive(0, 3'd7, 32'hF6);
        drive(2, 3'd7, 32'hF7);
        tick();
        flush = 1'b0;
        idle_all();
        chk("s4_num", cdb_num, 0);
        chk("s4_src", cdb_src, 3);
        chk("s4_pending", pending, 0);
        chk("s4_ready", req_ready, 3'b111);
        for (int i = 0; i < 4; i++) begin
            tick();
        end

        // Tag 0 is consumed without effect
        drive(2, 3'd0, 32'hDEAD);
        tick();
        chk("s5_ready", req_ready, 3'b111);
        chk("s5_pending", pending, 0);
        idle_all();
        tick();
        tick();

        // Asynchronous reset mid-burst
        drive(0, 3'd1, 32'h60);
        drive(1, 3'd2, 32'h61);
        drive(2, 3'd3, 32'h62);
        tick();
        drive(0, 3'd4, 32'h63);
        drive(1, 3'd5, 32'h64);
        drive(2, 3'd6, 32'h65);
        expect_bcast(3'd1, 32'h60, 2'd0);
        tick();
        idle_all();
        chk("s6_burst_active", cdb_num, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        drive(0, 3'd2, 32'h70);
        expect_bcast(3'd2, 32'h70, 2'd0);
        tick();
        idle_all();
        tick();
        chk("s6_post_reset", cdb_num, 2);
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
